// File: rtl/lfsr_8bit_pkg.sv
// Shared LFSR definitions for the 8-bit generator and checker:
// state encoding, Galois tap mask and the next-state function.
package lfsr_8bit_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lfsr_state_e;

  // x^8+x^4+x^3+x^2+1 in Galois form: the bit shifted out feeds bits 7, 3, 2, 1
  localparam logic [7:0] LFSR8_TAPS = 8'h0E;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] x);
    lfsr8_next = {x[0], x[7:1]} ^ (x[0] ? LFSR8_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/lfsr_8bit_checker.sv
// Locks onto a received 8-bit Galois LFSR sequence and counts mismatches once locked.
// Optional repeated-sample detector enabled by defining LFSR_CHECKER_STUCK_DET_EN.
module lfsr_8bit_checker
  import lfsr_8bit_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [7:0]           data_i,
  input  logic                 clear_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 stuck_o
);

  localparam logic [3:0] LockCnt   = 4'(LOCK_CNT);
  localparam logic [3:0] UnlockCnt = 4'(UNLOCK_CNT);

  lfsr_state_e            state_q, state_d;
  logic [7:0]             expected_q, expected_d;
  logic                   have_prev_q, have_prev_d;
  logic [3:0]             match_cnt_q, match_cnt_d;
  logic [3:0]             miss_cnt_q, miss_cnt_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   sample_ok;
  logic [3:0]             match_inc;
  logic [3:0]             miss_inc;

  // Zero is the LFSR fixed point, so it never counts as a match
  assign sample_ok = (data_i != 8'h00) && (data_i == expected_q);
  assign match_inc = match_cnt_q + 4'd1;
  assign miss_inc  = miss_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    have_prev_d = have_prev_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (clear_i) begin
      state_d     = HUNT;
      have_prev_d = 1'b0;
      match_cnt_d = 4'd0;
      miss_cnt_d  = 4'd0;
      err_cnt_d   = '0;
    end else if (valid_i) begin
      unique case (state_q)
        HUNT: begin
          expected_d  = lfsr8_next(data_i);
          have_prev_d = 1'b1;
          if (have_prev_q && sample_ok) begin
            match_cnt_d = match_inc;
            if (match_inc == LockCnt) begin
              state_d    = LOCKED;
              miss_cnt_d = 4'd0;
            end
          end else begin
            match_cnt_d = 4'd0;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction advances whether or not the sample agreed
          expected_d = lfsr8_next(expected_q);
          if (sample_ok) begin
            miss_cnt_d = 4'd0;
          end else begin
            err_d      = 1'b1;
            miss_cnt_d = miss_inc;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            if (miss_inc == UnlockCnt) begin
              state_d     = HUNT;
              have_prev_d = 1'b0;
              match_cnt_d = 4'd0;
              miss_cnt_d  = 4'd0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= HUNT;
      expected_q  <= 8'h00;
      have_prev_q <= 1'b0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      have_prev_q <= have_prev_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked_o  = (state_q == LOCKED);
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

`ifdef LFSR_CHECKER_STUCK_DET_EN
  logic [7:0] last_q;
  logic       have_last_q;
  logic [2:0] rep_cnt_q;
  logic       stuck_q;

  // Counts valid samples equal to the previous one; flag after the fourth repeat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q      <= 8'h00;
      have_last_q <= 1'b0;
      rep_cnt_q   <= 3'd0;
      stuck_q     <= 1'b0;
    end else if (clear_i) begin
      have_last_q <= 1'b0;
      rep_cnt_q   <= 3'd0;
      stuck_q     <= 1'b0;
    end else if (valid_i) begin
      last_q      <= data_i;
      have_last_q <= 1'b1;
      if (have_last_q && (data_i == last_q)) begin
        if (rep_cnt_q != 3'd4) begin
          rep_cnt_q <= rep_cnt_q + 3'd1;
        end
        stuck_q <= (rep_cnt_q >= 3'd3);
      end else begin
        rep_cnt_q <= 3'd0;
        stuck_q   <= 1'b0;
      end
    end
  end

  assign stuck_o = stuck_q;
`else
  assign stuck_o = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_8bit_checker.sv
// Self-checking bench for lfsr_8bit_checker: directed scenarios plus a randomized
// stream compared against a behavioural model of the lock/error rules.
module tb_lfsr_8bit_checker;

  localparam int LockN   = 4;
  localparam int UnlockN = 3;
  localparam int CntW    = 16;

  logic            clk_i;
  logic            rst_ni;
  logic            valid_i;
  logic [7:0]      data_i;
  logic            clear_i;
  logic            locked_o;
  logic            err_o;
  logic [CntW-1:0] err_cnt_o;
  logic            stuck_o;

  int vectors;
  int miscompares;

  // Behavioural model state
  bit        mLocked;
  bit        mHavePrev;
  bit [7:0]  mExp;
  int        mRun;
  int        mMiss;
  bit        mErr;
  int        mErrCnt;
  bit        mHaveLast;
  bit [7:0]  mLast;
  int        mRep;
  bit        mStuck;

  lfsr_8bit_checker #(
    .LOCK_CNT  (LockN),
    .UNLOCK_CNT(UnlockN),
    .ERR_CNT_W (CntW)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .clear_i  (clear_i),
    .locked_o (locked_o),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o),
    .stuck_o  (stuck_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Successor written as a polynomial step: drop bit 0, fold it back in at 0x8E
  function automatic bit [7:0] refNext(input bit [7:0] x);
    return (x >> 1) ^ ((x % 2 == 1) ? 8'h8E : 8'h00);
  endfunction

  task automatic modelReset();
    mLocked = 0; mHavePrev = 0; mExp = 8'h00; mRun = 0; mMiss = 0;
    mErr = 0; mErrCnt = 0; mHaveLast = 0; mLast = 8'h00; mRep = 0; mStuck = 0;
  endtask

  task automatic modelStep(input bit v, input bit [7:0] d, input bit c);
    bit good;
    mErr = 0;
    if (c) begin
      mLocked = 0; mHavePrev = 0; mRun = 0; mMiss = 0; mErrCnt = 0;
      mHaveLast = 0; mRep = 0; mStuck = 0;
    end else if (v) begin
      good = mHavePrev && (d != 0) && (d == mExp);
      if (!mLocked) begin
        mRun = good ? mRun + 1 : 0;
        mExp = refNext(d);
        mHavePrev = 1;
        if (mRun == LockN) begin
          mLocked = 1;
          mMiss = 0;
        end
      end else begin
        mExp = refNext(mExp);
        if (good) mMiss = 0;
        else begin
          mErr = 1;
          if (mErrCnt < (1 << CntW) - 1) mErrCnt++;
          mMiss++;
          if (mMiss == UnlockN) begin
            mLocked = 0; mHavePrev = 0; mRun = 0; mMiss = 0;
          end
        end
      end
      mRep = (mHaveLast && d == mLast) ? mRep + 1 : 0;
      mLast = d;
      mHaveLast = 1;
`ifdef LFSR_CHECKER_STUCK_DET_EN
      mStuck = (mRep >= 4);
`else
      mStuck = 0;
`endif
    end
  endtask

  task automatic stepCycle(input bit v, input bit [7:0] d, input bit c);
    @(negedge clk_i);
    valid_i = v; data_i = d; clear_i = c;
    @(posedge clk_i);
    modelStep(v, d, c);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_ni = 1'b0; valid_i = 1'b0; data_i = 8'h00; clear_i = 1'b0;
    modelReset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic lockUp();
    bit [7:0] seq [5] = '{8'hAC, 8'h56, 8'h2B, 8'h9B, 8'hC3};
    foreach (seq[i]) stepCycle(1'b1, seq[i], 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; valid_i = 1'b0; data_i = 8'h00; clear_i = 1'b0;
    modelReset();
    #1;
    vectors++;
    if ({locked_o, err_o, err_cnt_o, stuck_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got locked=%b err=%b cnt=%0d stuck=%b, want all 0",
               locked_o, err_o, err_cnt_o, stuck_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_lock_acquire();
    bit [7:0] seq [5] = '{8'hAC, 8'h56, 8'h2B, 8'h9B, 8'hC3};
    doReset();
    foreach (seq[i]) begin
      stepCycle(1'b1, seq[i], 1'b0);
      vectors++;
      if (locked_o !== mLocked) begin
        miscompares++;
        $display("[TB] FAIL lock_progress[%0d]: locked=%b want %b", i, locked_o, mLocked);
      end
    end
    vectors++;
    if (locked_o !== 1'b1 || err_cnt_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL lock_after_C3: locked=%b cnt=%0d, want locked=1 cnt=0", locked_o, err_cnt_o);
    end
  endtask

  task automatic test_single_error();
    int pulses;
    doReset();
    lockUp();
    pulses = 0;
    stepCycle(1'b1, 8'h00, 1'b0);
    if (err_o === 1'b1) pulses++;
    for (int i = 0; i < 6; i++) begin
      stepCycle(1'b1, mExp, 1'b0);
      if (err_o === 1'b1) pulses++;
      vectors++;
      if (locked_o !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL single_err_locked[%0d]: locked=%b want 1", i, locked_o);
      end
    end
    vectors++;
    if (pulses != 1 || err_cnt_o !== CntW'(1)) begin
      miscompares++;
      $display("[TB] FAIL single_err_count: pulses=%0d cnt=%0d, want 1 and 1", pulses, err_cnt_o);
    end
  endtask

  task automatic test_loss_of_lock();
    bit [7:0] seq [5] = '{8'hAC, 8'h56, 8'h2B, 8'h9B, 8'hC3};
    doReset();
    lockUp();
    for (int i = 0; i < 3; i++) begin
      stepCycle(1'b1, 8'h11, 1'b0);
      vectors++;
      if (err_o !== 1'b1 || locked_o !== (i < 2)) begin
        miscompares++;
        $display("[TB] FAIL unlock_step[%0d]: err=%b locked=%b, want err=1 locked=%b",
                 i, err_o, locked_o, (i < 2));
      end
    end
    vectors++;
    if (err_cnt_o !== CntW'(3)) begin
      miscompares++;
      $display("[TB] FAIL unlock_count: cnt=%0d want 3", err_cnt_o);
    end
    foreach (seq[i]) stepCycle(1'b1, seq[i], 1'b0);
    vectors++;
    if (locked_o !== 1'b1 || err_cnt_o !== CntW'(3) || err_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL relock: locked=%b cnt=%0d err=%b, want 1,3,0", locked_o, err_cnt_o, err_o);
    end
  endtask

  task automatic test_gaps_and_clear();
    doReset();
    lockUp();
    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < 5; g++) stepCycle(1'b0, 8'h00, 1'b0);
      stepCycle(1'b1, mExp, 1'b0);
      vectors++;
      if (locked_o !== 1'b1 || err_o !== 1'b0 || err_cnt_o !== '0) begin
        miscompares++;
        $display("[TB] FAIL gap_hold[%0d]: locked=%b err=%b cnt=%0d, want 1,0,0", k, locked_o, err_o, err_cnt_o);
      end
    end
    stepCycle(1'b1, 8'h11, 1'b0);
    stepCycle(1'b1, 8'h00, 1'b1);
    vectors++;
    if (locked_o !== 1'b0 || err_o !== 1'b0 || err_cnt_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL clear_priority: locked=%b err=%b cnt=%0d, want 0,0,0", locked_o, err_o, err_cnt_o);
    end
  endtask

  task automatic test_reset_mid_lock();
    doReset();
    lockUp();
    stepCycle(1'b1, 8'h00, 1'b0);
    @(negedge clk_i);
    valid_i = 1'b1; data_i = 8'h33;
    rst_ni = 1'b0;
    modelReset();
    #1;
    vectors++;
    if ({locked_o, err_o, err_cnt_o, stuck_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_lock: locked=%b err=%b cnt=%0d stuck=%b, want all 0",
               locked_o, err_o, err_cnt_o, stuck_o);
    end
    @(posedge clk_i);
    #1;
    vectors++;
    if (err_o !== 1'b0 || locked_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: locked=%b err=%b, want 0,0", locked_o, err_o);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_ni = 1'b1;
  endtask

  task automatic test_stuck();
    bit want;
    doReset();
    for (int i = 0; i < 5; i++) begin
      stepCycle(1'b1, 8'h5A, 1'b0);
      vectors++;
      if (stuck_o !== mStuck) begin
        miscompares++;
        $display("[TB] FAIL stuck_seq[%0d]: stuck=%b want %b", i, stuck_o, mStuck);
      end
    end
`ifdef LFSR_CHECKER_STUCK_DET_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    vectors++;
    if (stuck_o !== want) begin
      miscompares++;
      $display("[TB] FAIL stuck_after_5: stuck=%b want %b", stuck_o, want);
    end
    stepCycle(1'b1, 8'h5B, 1'b0);
    vectors++;
    if (stuck_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stuck_release: stuck=%b want 0", stuck_o);
    end
  endtask

  task automatic test_random();
    bit        v, c;
    bit [7:0]  d;
    int        r;
    doReset();
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 99);
      if (r < 80 && mHavePrev) d = mExp;
      else if (r < 85) d = 8'h00;
      else if (r < 90) d = mLast;
      else d = 8'($urandom_range(0, 255));
      stepCycle(v, d, c);
      vectors++;
      if (locked_o !== mLocked || err_o !== mErr || err_cnt_o !== CntW'(mErrCnt) || stuck_o !== mStuck) begin
        miscompares++;
        $display("[TB] FAIL random[%0d]: got locked=%b err=%b cnt=%0d stuck=%b, want %b %b %0d %b",
                 n, locked_o, err_o, err_cnt_o, stuck_o, mLocked, mErr, mErrCnt, mStuck);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_ni = 1'b1; valid_i = 1'b0; data_i = 8'h00; clear_i = 1'b0;
    modelReset();
    test_reset();
    test_lock_acquire();
    test_single_error();
    test_loss_of_lock();
    test_gaps_and_clear();
    test_reset_mid_lock();
    test_stuck();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
